// File: rtl/req_capture_encoder.sv
// Sticky request capture with fixed-priority or round-robin arbitration.
// The winner is presented as a registered binary code and one-hot grant under a valid/ack handshake.
module req_capture_encoder #(
    parameter int N           = 8,
    parameter int W           = 3,
    parameter int ROUND_ROBIN = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] code,
    output logic [N-1:0] grant_onehot,
    output logic [N-1:0] pending,
    output logic         dropped
);

    typedef enum logic {IDLE, PRESENT} state_t;

    generate
        if (W != $clog2(N)) begin : g_bad_w
            $error("req_capture_encoder: W must equal log2(N)");
        end
    endgenerate

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         valid_q, valid_d;
    logic [W-1:0] code_q, code_d;
    logic [N-1:0] grant_q, grant_d;
    logic         dropped_q, dropped_d;
    logic [W-1:0] last_grant_q, last_grant_d;
    logic [N-1:0] clr;
    logic [W-1:0] winner;

    function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] p);
        logic [W-1:0] sel;
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) sel = W'(i);
        end
        return sel;
    endfunction

    // Scan starts one past the last grant; W-bit addition wraps at N since N is a power of two.
    function automatic logic [W-1:0] pick_rr(input logic [N-1:0] p, input logic [W-1:0] last);
        logic [W-1:0] sel;
        logic [W-1:0] idx;
        logic         found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = last + W'(i + 1);
            if (!found && p[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        code_d       = code_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        winner       = (ROUND_ROBIN != 0) ? pick_rr(pending_q, last_grant_q) : pick_fixed(pending_q);
        clr          = (valid_q && ack) ? grant_q : '0;
        // A request landing on the clearing edge re-arms the bit.
        pending_d    = (pending_q & ~clr) | req_in;
        dropped_d    = |(req_in & pending_q & ~clr);

        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    code_d  = winner;
                    grant_d = N'(1) << winner;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    last_grant_d = code_q;
                    grant_d      = '0;
                    valid_d      = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            valid_q      <= 1'b0;
            code_q       <= '0;
            grant_q      <= '0;
            dropped_q    <= 1'b0;
            last_grant_q <= W'(N - 1);
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            valid_q      <= valid_d;
            code_q       <= code_d;
            grant_q      <= grant_d;
            dropped_q    <= dropped_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign valid        = valid_q;
    assign code         = code_q;
    assign grant_onehot = grant_q;
    assign pending      = pending_q;
    assign dropped      = dropped_q;

endmodule

// File: tb/tb_req_capture_encoder.sv
// Bench for req_capture_encoder: a fixed-priority and a round-robin instance share stimulus
// and are compared every cycle against a behavioural model, plus directed sequence checks.
module tb_req_capture_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req_in;
    logic ack;

    logic [1:0]        valid;
    logic [1:0][W-1:0] code;
    logic [1:0][N-1:0] grant;
    logic [1:0][N-1:0] pend;
    logic [1:0]        dropped;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [N-1:0] pend;
        logic         valid;
        logic [W-1:0] code;
        logic [W-1:0] last;
        logic         drop;
    } mdl_t;

    mdl_t m [2];

    req_capture_encoder #(.N(N), .W(W), .ROUND_ROBIN(0)) u_fix (
        .clk(clk), .rst(rst), .req_in(req_in), .ack(ack),
        .valid(valid[0]), .code(code[0]), .grant_onehot(grant[0]),
        .pending(pend[0]), .dropped(dropped[0])
    );

    req_capture_encoder #(.N(N), .W(W), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst(rst), .req_in(req_in), .ack(ack),
        .valid(valid[1]), .code(code[1]), .grant_onehot(grant[1]),
        .pending(pend[1]), .dropped(dropped[1])
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] p, input int rr, input int last);
        if (rr == 0) begin
            for (int i = N - 1; i >= 0; i--) if (p[i]) return i;
        end else begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (last + 1 + i) % N;
                if (p[j]) return j;
            end
        end
        return 0;
    endfunction

    function automatic mdl_t step(input mdl_t s, input logic [N-1:0] r, input logic a, input int rr);
        mdl_t n;
        logic [N-1:0] clr;
        n = s;
        clr = 0;
        if (s.valid && a) clr[s.code] = 1'b1;
        n.drop = |(r & s.pend & ~clr);
        n.pend = (s.pend & ~clr) | r;
        if (!s.valid) begin
            if (s.pend != 0) begin
                n.code  = W'(pick(s.pend, rr, int'(s.last)));
                n.valid = 1'b1;
            end
        end else if (a) begin
            n.last  = s.code;
            n.valid = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) m[k] <= '{pend: '0, valid: 1'b0, code: '0, last: W'(N - 1), drop: 1'b0};
        end else begin
            for (int k = 0; k < 2; k++) m[k] <= step(m[k], req_in, ack, k);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            logic [N-1:0] eg;
            eg = 0;
            if (m[k].valid) eg[m[k].code] = 1'b1;
            chk($sformatf("%s[%0d].valid", tag, k), 32'(valid[k]), 32'(m[k].valid));
            chk($sformatf("%s[%0d].code", tag, k), 32'(code[k]), 32'(m[k].code));
            chk($sformatf("%s[%0d].grant", tag, k), 32'(grant[k]), 32'(eg));
            chk($sformatf("%s[%0d].pending", tag, k), 32'(pend[k]), 32'(m[k].pend));
            chk($sformatf("%s[%0d].dropped", tag, k), 32'(dropped[k]), 32'(m[k].drop));
        end
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_in = '0;
        ack = 1'b0;
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int k, input string tag);
        int cnt;
        cnt = 0;
        while (!valid[k] && cnt < 20) begin
            cyc(tag);
            cnt++;
        end
        if (!valid[k]) chk({tag, "_timeout"}, 32'(valid[k]), 32'd1);
    endtask

    int q0[$];
    int q1[$];

    initial begin
        rst = 1'b1;
        req_in = '0;
        ack = 1'b0;
        repeat (2) @(negedge clk);
        check_all("rst");
        chk("rst_last_scan_start", 32'(pend[1]), 32'h0);
        rst = 1'b0;

        // 1: single request held without ack, then acked
        req_in = 8'h20;
        cyc("t1_set");
        req_in = '0;
        chk("t1_pend", 32'(pend[0]), 32'h20);
        chk("t1_valid_not_yet", 32'(valid[0]), 32'h0);
        repeat (10) begin
            cyc("t1_hold");
            chk("t1_code", 32'(code[0]), 32'd5);
            chk("t1_grant", 32'(grant[0]), 32'h20);
        end
        ack = 1'b1;
        cyc("t1_ack");
        ack = 1'b0;
        chk("t1_valid_after_ack", 32'(valid[0]), 32'h0);
        chk("t1_pend_after_ack", 32'(pend[0]), 32'h0);

        // 2: three requests, ack tied high
        do_reset();
        req_in = 8'h91;
        ack = 1'b1;
        cyc("t2");
        req_in = '0;
        for (int i = 0; i < 10; i++) begin
            cyc("t2");
            if (valid[0]) q0.push_back(int'(code[0]));
            if (valid[1]) q1.push_back(int'(code[1]));
        end
        chk("t2_fix_count", 32'(q0.size()), 32'd3);
        chk("t2_rr_count", 32'(q1.size()), 32'd3);
        if (q0.size() == 3) begin
            chk("t2_fix_0", 32'(q0[0]), 32'd7);
            chk("t2_fix_1", 32'(q0[1]), 32'd4);
            chk("t2_fix_2", 32'(q0[2]), 32'd0);
        end
        if (q1.size() == 3) begin
            chk("t2_rr_0", 32'(q1[0]), 32'd0);
            chk("t2_rr_1", 32'(q1[1]), 32'd4);
            chk("t2_rr_2", 32'(q1[2]), 32'd7);
        end
        chk("t2_pend_end", 32'(pend[0]), 32'h0);
        chk("t2_valid_end", 32'(valid[0]), 32'h0);
        ack = 1'b0;

        // 3: round-robin over a full pending register, re-armed on every ack edge
        do_reset();
        q1.delete();
        req_in = 8'hFF;
        ack = 1'b1;
        cyc("t3");
        req_in = '0;
        for (int i = 0; i < 40 && q1.size() < 9; i++) begin
            cyc("t3");
            req_in = '0;
            if (valid[1]) begin
                q1.push_back(int'(code[1]));
                req_in = 8'hFF;
            end
        end
        chk("t3_count", 32'(q1.size()), 32'd9);
        for (int i = 0; i < q1.size(); i++) chk($sformatf("t3_rr_seq%0d", i), 32'(q1[i]), 32'(i % 8));
        req_in = '0;
        ack = 1'b0;

        // 4: request on the ack edge survives; request on a non-ack edge drops
        do_reset();
        req_in = 8'h08;
        cyc("t4");
        req_in = '0;
        wait_valid(0, "t4_wait");
        chk("t4_code", 32'(code[0]), 32'd3);
        ack = 1'b1;
        req_in = 8'h08;
        cyc("t4_ackedge");
        ack = 1'b0;
        req_in = '0;
        chk("t4_pend_kept", 32'(pend[0][3]), 32'd1);
        chk("t4_no_drop", 32'(dropped[0]), 32'd0);
        cyc("t4_regrant");
        chk("t4_regrant_valid", 32'(valid[0]), 32'd1);
        chk("t4_regrant_code", 32'(code[0]), 32'd3);
        req_in = 8'h08;
        cyc("t4_drop");
        req_in = '0;
        chk("t4_dropped", 32'(dropped[0]), 32'd1);
        cyc("t4_drop_end");
        chk("t4_dropped_clear", 32'(dropped[0]), 32'd0);

        // 5: asynchronous reset mid-cycle
        do_reset();
        req_in = 8'hC3;
        cyc("t5");
        req_in = '0;
        wait_valid(0, "t5_wait");
        #2 rst = 1'b1;
        #1;
        chk("t5_valid", 32'(valid[0]), 32'h0);
        chk("t5_code", 32'(code[0]), 32'h0);
        chk("t5_grant", 32'(grant[0]), 32'h0);
        chk("t5_pend", 32'(pend[0]), 32'h0);
        chk("t5_rr_pend", 32'(pend[1]), 32'h0);
        check_all("t5_async");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            cyc("t5_idle");
            chk("t5_no_grant", 32'(valid[0]), 32'h0);
        end
        req_in = 8'h01;
        cyc("t5_new");
        req_in = '0;
        cyc("t5_new");
        chk("t5_new_grant", 32'(valid[0]), 32'h1);

        // 6: ack while idle has no effect
        do_reset();
        ack = 1'b1;
        cyc("t6");
        ack = 1'b0;
        cyc("t6");
        chk("t6_valid", 32'(valid[0]), 32'h0);
        chk("t6_code", 32'(code[0]), 32'h0);
        chk("t6_pend", 32'(pend[0]), 32'h0);

        // random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            req_in = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            ack = 1'(($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                cyc("rand_rst");
                rst = 1'b0;
            end else begin
                cyc("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
